// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data-memory port arbiter between CPU MEM stage and DMA/loader port
// Optional DMA starvation guard is compiled in when DMEM_ARB_STARVE_EN is defined.
module dmem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int BURST_MAX    = 8,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dma_valid,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   input  logic              dma_last,
   output logic              dma_ready,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_rvalid,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        owner
);

   localparam int CNT_W = $clog2(BURST_MAX + 1);

   typedef enum logic {
      IDLE      = 1'b0,
      DMA_BURST = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
   logic              dma_rvalid_q, dma_rvalid_d;

   logic             cpu_req;
   logic             starve_hit;
   logic             grant_dma;
   logic             grant_cpu;
   logic             accept;
   logic             burst_start;
   logic [CNT_W-1:0] cnt_inc;
   logic             cnt_full;

   assign cpu_req  = cpu_read | cpu_write;
   assign cnt_inc  = beat_cnt_q + CNT_W'(1);
   assign cnt_full = (cnt_inc == CNT_W'(BURST_MAX));

   // Grants are masked while reset is held so every output reads as idle.
   assign grant_dma   = rst_n & ((state_q == DMA_BURST) | starve_hit | (~cpu_req & dma_valid));
   assign grant_cpu   = rst_n & ~grant_dma & cpu_req;
   assign accept      = dma_valid & grant_dma;
   assign burst_start = (state_q == IDLE) & accept & ~dma_last & ~cnt_full;

`ifdef DMEM_ARB_STARVE_EN
   localparam int SC_W = $clog2(STARVE_LIMIT + 1);

   logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;

   assign starve_hit = (starve_cnt_q == SC_W'(STARVE_LIMIT));

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (grant_dma) begin
         starve_cnt_d = '0;
      end else if (grant_cpu && dma_valid && !starve_hit) begin
         starve_cnt_d = starve_cnt_q + SC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end
`else
   assign starve_hit = 1'b0;
`endif

   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      cpu_rdata = '0;
      cpu_stall = 1'b0;
      dma_ready = 1'b0;
      owner     = 2'b00;
      if (grant_dma) begin
         mem_read  = dma_valid & ~dma_we;
         mem_write = dma_valid & dma_we;
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
         dma_ready = 1'b1;
         cpu_stall = cpu_req;
         owner     = ((state_q == DMA_BURST) || burst_start) ? 2'b10 : 2'b11;
      end else if (grant_cpu) begin
         mem_read  = cpu_read & ~cpu_write;
         mem_write = cpu_write;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         cpu_rdata = mem_rdata;
         owner     = 2'b01;
      end
   end

   always_comb begin
      state_d      = state_q;
      beat_cnt_d   = beat_cnt_q;
      dma_rvalid_d = accept & ~dma_we;
      dma_rdata_d  = dma_rvalid_d ? mem_rdata : dma_rdata_q;
      if (accept) begin
         if (state_q == IDLE) begin
            if (burst_start) begin
               state_d    = DMA_BURST;
               beat_cnt_d = cnt_inc;
            end
         end else if (dma_last || cnt_full) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
         end else begin
            beat_cnt_d = cnt_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         beat_cnt_q   <= '0;
         dma_rdata_q  <= '0;
         dma_rvalid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_cnt_q   <= beat_cnt_d;
         dma_rdata_q  <= dma_rdata_d;
         dma_rvalid_q <= dma_rvalid_d;
      end
   end

   assign dma_rdata  = dma_rdata_q;
   assign dma_rvalid = dma_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter with a DMA read-data scoreboard
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_read, cpu_write;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_stall;
   logic        dma_valid, dma_we, dma_last, dma_ready, dma_rvalid;
   logic [31:0] dma_addr, dma_wdata, dma_rdata;
   logic        mem_read, mem_write;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  owner;

   logic [31:0] mem [0:255];
   logic [31:0] sb [$];
   int          n_vec = 0;
   int          n_err = 0;

   dmem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .BURST_MAX(8), .STARVE_LIMIT(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_valid(dma_valid), .dma_we(dma_we), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_last(dma_last), .dma_ready(dma_ready),
      .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[9:2]];
   always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic sample(input string tag, input logic e_stall, input logic e_ready,
                         input logic [1:0] e_owner);
      logic [31:0] exp_d;
      @(negedge clk);
      chk({tag, ".rvalid"}, 32'(dma_rvalid), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
         exp_d = sb.pop_front();
         chk({tag, ".rdata"}, dma_rdata, exp_d);
      end
      chk({tag, ".stall"}, 32'(cpu_stall), 32'(e_stall));
      chk({tag, ".ready"}, 32'(dma_ready), 32'(e_ready));
      chk({tag, ".owner"}, 32'(owner), 32'(e_owner));
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      cpu_read = r; cpu_write = w; cpu_addr = a; cpu_wdata = d;
   endtask

   task automatic dma(input logic v, input logic we, input logic last,
                      input logic [31:0] a, input logic [31:0] d);
      dma_valid = v; dma_we = we; dma_last = last; dma_addr = a; dma_wdata = d;
   endtask

   initial begin
      cpu(0, 0, 0, 0);
      dma(0, 0, 0, 0, 0);
      sample("reset", 0, 0, 2'b00);
      chk("reset.mem_read", 32'(mem_read), 0);
      adv();
      rst_n = 1'b1;

      cpu(0, 1, 32'h10, 32'hDEADBEEF);
      sample("cpu_wr0", 0, 0, 2'b01);
      chk("cpu_wr0.mem_write", 32'(mem_write), 1);
      adv();
      cpu(0, 1, 32'h20, 32'h12345678);
      sample("cpu_wr1", 0, 0, 2'b01);
      adv();
      cpu(1, 0, 32'h10, 0);
      sample("cpu_rd", 0, 0, 2'b01);
      chk("cpu_rd.rdata", cpu_rdata, 32'hDEADBEEF);
      adv();
      cpu(0, 0, 0, 0);
      sample("idle", 0, 0, 2'b00);
      adv();

      // 3-beat write burst, CPU joins on beat 2
      dma(1, 1, 0, 32'h100, 32'hA0);
      sample("wb1", 0, 1, 2'b10);
      adv();
      cpu(1, 0, 32'h10, 0);
      dma(1, 1, 0, 32'h104, 32'hA1);
      sample("wb2", 1, 1, 2'b10);
      adv();
      dma(1, 1, 1, 32'h108, 32'hA2);
      sample("wb3", 1, 1, 2'b10);
      adv();
      dma(0, 0, 0, 0, 0);
      sample("wb_cpu", 0, 0, 2'b01);
      chk("wb_cpu.rdata", cpu_rdata, 32'hDEADBEEF);
      adv();
      cpu(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) chk($sformatf("wb_mem%0d", i), mem[64+i], 32'hA0 + i);

      dma(1, 0, 1, 32'h20, 0);
      sample("rd1", 0, 1, 2'b11);
      sb.push_back(32'h12345678);
      adv();
      dma(0, 0, 0, 0, 0);
      sample("rd1_rsp", 0, 0, 2'b00);
      adv();

      // 10-beat burst without dma_last: forced release after beat 8
      for (int i = 0; i < 8; i++) begin
         if (i == 1) cpu(1, 0, 32'h10, 0);
         dma(1, 1, 0, 32'h180 + 4 * i, 32'hB00 + i);
         sample($sformatf("fb%0d", i + 1), i != 0, 1, 2'b10);
         adv();
      end
      dma(1, 1, 0, 32'h1A0, 32'hB08);
      sample("fb_rel", 0, 0, 2'b01);
      chk("fb_rel.rdata", cpu_rdata, 32'hDEADBEEF);
      adv();
      cpu(0, 0, 0, 0);
      sample("fb9", 0, 1, 2'b10);
      adv();
      dma(1, 1, 1, 32'h1A4, 32'hB09);
      sample("fb10", 0, 1, 2'b10);
      adv();
      dma(0, 0, 0, 0, 0);
      sample("fb_idle", 0, 0, 2'b00);
      adv();
      for (int i = 0; i < 10; i++) chk($sformatf("fb_mem%0d", i), mem[96+i], 32'hB00 + i);

      cpu(1, 0, 32'h10, 0);
      dma(1, 0, 1, 32'h20, 0);
`ifdef DMEM_ARB_STARVE_EN
      for (int i = 0; i < 4; i++) begin
         sample($sformatf("starve_cpu%0d", i + 1), 0, 0, 2'b01);
         adv();
      end
      sample("starve_dma", 1, 1, 2'b11);
      sb.push_back(32'h12345678);
      adv();
      sample("starve_after", 0, 0, 2'b01);
      adv();
`else
      for (int i = 0; i < 6; i++) begin
         sample($sformatf("strict_cpu%0d", i + 1), 0, 0, 2'b01);
         adv();
      end
`endif
      cpu(0, 0, 0, 0);
      dma(0, 0, 0, 0, 0);
      sample("idle2", 0, 0, 2'b00);
      adv();

      // reset in the middle of a read burst
      dma(1, 0, 0, 32'h100, 0);
      sample("rb1", 0, 1, 2'b10);
      sb.push_back(32'hA0);
      adv();
      dma(1, 0, 0, 32'h104, 0);
      rst_n = 1'b0;
      sb.delete();
      sample("rb2_rst", 0, 0, 2'b00);
      chk("rb2_rst.mem_read", 32'(mem_read), 0);
      adv();
      dma(0, 0, 0, 0, 0);
      sample("rst_hold", 0, 0, 2'b00);
      adv();
      rst_n = 1'b1;
      sample("rst_rel", 0, 0, 2'b00);
      adv();
      sample("rst_rel2", 0, 0, 2'b00);
      adv();
      dma(1, 0, 1, 32'h20, 0);
      sample("post_rst", 0, 1, 2'b11);
      sb.push_back(32'h12345678);
      adv();
      dma(0, 0, 0, 0, 0);
      sample("post_rst_rsp", 0, 0, 2'b00);
      adv();
      chk("sb_empty", 32'(sb.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
